// File: rtl/ahb_bus_arbiter.sv
// Registered AHB manager arbiter: fixed-priority or round-robin winner selection,
// HREADY-qualified zero-bubble handover, HMASTLOCK hold, bounded tenure, data-phase owner.
module ahb_bus_arbiter #(
  parameter int unsigned NUM_MANAGERS = 4,
  parameter int unsigned RR_MODE      = 0,
  parameter int unsigned MAX_HOLD     = 16,
  parameter int unsigned CNT_W        = 5
) (
  input  logic                            HCLK,
  input  logic                            HRESETn,
  input  logic [NUM_MANAGERS-1:0]         Req,
  input  logic [NUM_MANAGERS-1:0]         Lock,
  input  logic                            HREADY,
  output logic [NUM_MANAGERS-1:0]         Grant,
  output logic                            GrantValid,
  output logic [$clog2(NUM_MANAGERS)-1:0] GrantIdx,
  output logic [NUM_MANAGERS-1:0]         DataOwner
);

  localparam int unsigned IW  = $clog2(NUM_MANAGERS);
  localparam int unsigned IW1 = IW + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = (MAX_HOLD == 0) ? {CNT_W{1'b1}} : CNT_W'(MAX_HOLD);

  typedef enum logic {IDLE, OWNED} state_e;

  state_e                  state_q, state_d;
  logic [NUM_MANAGERS-1:0] grant_q, grant_d;
  logic [NUM_MANAGERS-1:0] downer_q;
  logic [IW-1:0]           idx_q, idx_d;
  logic [IW-1:0]           ptr_q, ptr_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  logic [NUM_MANAGERS-1:0] arb_req;
  logic [IW:0]             cand;
  logic                    win_found;
  logic [IW-1:0]           win_idx;
  logic                    take;

  // The current owner is always excluded: it is either not requesting (rule 2)
  // or being forced off (rule 3), so one masked vector serves every arbitration.
  always_comb begin
    arb_req   = Req & ~grant_q;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < NUM_MANAGERS; i++) begin
      cand = ((RR_MODE != 0) ? {1'b0, ptr_q} : '0) + IW1'(i);
      if (cand >= IW1'(NUM_MANAGERS)) cand = cand - IW1'(NUM_MANAGERS);
      if (!win_found && arb_req[cand[IW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IW-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    take    = 1'b0;
    case (state_q)
      IDLE: take = win_found;
      OWNED: begin
        if (Lock[idx_q]) begin
          if (cnt_q != CNT_SAT) cnt_d = cnt_q + 1'b1;
        end else if (!Req[idx_q]) begin
          if (win_found) begin
            take = 1'b1;
          end else begin
            state_d = IDLE;
            grant_d = '0;
            idx_d   = '0;
            cnt_d   = '0;
          end
        // >= so a count left saturated by a lock still forces handover once unlocked
        end else if ((MAX_HOLD != 0) && (cnt_q >= CNT_LAST) && win_found) begin
          take = 1'b1;
        end else if (cnt_q != CNT_SAT) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (take) begin
      state_d          = OWNED;
      grant_d          = '0;
      grant_d[win_idx] = 1'b1;
      idx_d            = win_idx;
      cnt_d            = '0;
      ptr_d            = (win_idx == IW'(NUM_MANAGERS - 1)) ? '0 : win_idx + 1'b1;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      downer_q <= '0;
      idx_q    <= '0;
      ptr_q    <= '0;
      cnt_q    <= '0;
    end else if (HREADY) begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      downer_q <= grant_q;
      idx_q    <= idx_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign Grant      = grant_q;
  assign GrantValid = |grant_q;
  assign GrantIdx   = idx_q;
  assign DataOwner  = downer_q;

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Directed bench for ahb_bus_arbiter: a fixed-priority and a round-robin instance
// (both MAX_HOLD=4) share stimulus; each step checks the instance of interest.
module tb_ahb_bus_arbiter;

  logic       HCLK = 1'b0;
  logic       HRESETn;
  logic [3:0] Req, Lock;
  logic       HREADY;

  logic [3:0] f_grant, f_do, r_grant, r_do;
  logic       f_gv, r_gv;
  logic [1:0] f_idx, r_idx;

  int errors = 0;
  int checks = 0;

  ahb_bus_arbiter #(.NUM_MANAGERS(4), .RR_MODE(0), .MAX_HOLD(4), .CNT_W(5)) u_fix (
    .HCLK(HCLK), .HRESETn(HRESETn), .Req(Req), .Lock(Lock), .HREADY(HREADY),
    .Grant(f_grant), .GrantValid(f_gv), .GrantIdx(f_idx), .DataOwner(f_do)
  );

  ahb_bus_arbiter #(.NUM_MANAGERS(4), .RR_MODE(1), .MAX_HOLD(4), .CNT_W(5)) u_rr (
    .HCLK(HCLK), .HRESETn(HRESETn), .Req(Req), .Lock(Lock), .HREADY(HREADY),
    .Grant(r_grant), .GrantValid(r_gv), .GrantIdx(r_idx), .DataOwner(r_do)
  );

  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic do_reset();
    Req = 4'b0000; Lock = 4'b0000; HREADY = 1'b1;
    HRESETn = 1'b0;
    #2;
    HRESETn = 1'b1;
  endtask

  initial begin
    logic [3:0] exp_g;
    int k;
    HRESETn = 1'b0; Req = 4'b0000; Lock = 4'b0000; HREADY = 1'b1;
    #3;
    chk("rst_grant", f_grant, 4'b0000);
    chk("rst_gv", f_gv, 1'b0);
    chk("rst_idx", f_idx, 2'd0);
    chk("rst_do", f_do, 4'b0000);
    #9;
    HRESETn = 1'b1;

    // Idle with no requests
    for (int i = 0; i < 5; i++) begin
      step();
      chk("idle_grant", f_grant, 4'b0000);
      chk("idle_gv", f_gv, 1'b0);
      chk("idle_do", f_do, 4'b0000);
    end

    // Fixed priority: lowest index wins, handover without bubble
    Req = 4'b1010;
    step();
    chk("fix_grant1", f_grant, 4'b0010);
    chk("fix_idx1", f_idx, 2'd1);
    chk("fix_gv1", f_gv, 1'b1);
    chk("fix_do1", f_do, 4'b0000);
    step();
    chk("fix_hold", f_grant, 4'b0010);
    chk("fix_do2", f_do, 4'b0010);
    Req = 4'b1000;
    step();
    chk("fix_hand", f_grant, 4'b1000);
    chk("fix_hand_idx", f_idx, 2'd3);
    chk("fix_hand_do", f_do, 4'b0010);

    // Round-robin fairness: drop the owner's request for one beat after each grant
    do_reset();
    Req = 4'b1111;
    step();
    chk("rr_first", r_grant, 4'b0001);
    k = 0;
    for (int i = 0; i < 4; i++) begin
      Req = 4'b1111 & ~(4'b0001 << k);
      step();
      k = (k + 1) % 4;
      exp_g = 4'b0001 << k;
      chk("rr_order", r_grant, exp_g);
      chk("rr_idx", r_idx, k);
      if (i == 1) chk("fix_vs_rr", f_grant, 4'b0001);
    end

    // Lock hold beyond MAX_HOLD, then HREADY stall freezes everything
    do_reset();
    Req = 4'b0011; Lock = 4'b0001;
    step();
    chk("lock_grant", f_grant, 4'b0001);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("lock_hold", f_grant, 4'b0001);
    end
    HREADY = 1'b0; Lock = 4'b0000; Req = 4'b0110;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_grant", f_grant, 4'b0001);
      chk("stall_do", f_do, 4'b0001);
      Req = 4'b0011;
    end
    HREADY = 1'b1;
    step();
    chk("unstall_grant", f_grant, 4'b0010);
    chk("unstall_do", f_do, 4'b0001);

    // Tenure limit: exactly four accepted beats, then forced handover
    do_reset();
    Req = 4'b0011;
    step();
    chk("ten_b0", f_grant, 4'b0001);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("ten_hold", f_grant, 4'b0001);
    end
    step();
    chk("ten_hand", f_grant, 4'b0010);
    chk("ten_gv", f_gv, 1'b1);

    // Sole requester keeps the bus indefinitely
    do_reset();
    Req = 4'b0001;
    step();
    for (int i = 0; i < 8; i++) begin
      step();
      chk("solo_hold", f_grant, 4'b0001);
    end

    // Asynchronous reset mid-burst restarts the round-robin pointer
    do_reset();
    Req = 4'b0100;
    step();
    chk("ar_grant", r_grant, 4'b0100);
    Req = 4'b1100;
    step();
    chk("ar_do", r_do, 4'b0100);
    #3;
    HRESETn = 1'b0;
    #1;
    chk("ar_clr_grant", r_grant, 4'b0000);
    chk("ar_clr_do", r_do, 4'b0000);
    chk("ar_clr_gv", r_gv, 1'b0);
    chk("ar_clr_idx", r_idx, 2'd0);
    #1;
    HRESETn = 1'b1;
    step();
    chk("ar_ptr0", r_grant, 4'b0100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
